rf_wport_arb: RTL and testbench

//  Arbitrates the single register-file write port between the in-order WB stage and a

---
 rtl/rf_wport_arb_if.sv | 28 ++
 rtl/rf_wport_arb.sv | 93 +++++++++
 tb/tb_rf_wport_arb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_arb_if.sv
// rf_wport_arb_if: WB, LU, scoreboard-query and regfile signals of the write-port arbiter
//   slave  - arbiter side (consumes wb_*/lu_*/qry_addr_i, drives stall/ready/hit/rf_*)
//   master - environment side (drives wb_*/lu_*/qry_addr_i)
interface rf_wport_arb_if;
    logic        wb_wen_i;
    logic [4:0]  wb_wdest_i;
    logic [31:0] wb_wdata_i;
    logic        wb_stall_o;
    logic        lu_valid_i;
    logic [4:0]  lu_wdest_i;
    logic [31:0] lu_wdata_i;
    logic        lu_ready_o;
    logic [4:0]  qry_addr_i;
    logic        qry_hit_o;
    logic        rf_wen_o;
    logic [4:0]  rf_wdest_o;
    logic [31:0] rf_wdata_o;

    modport slave (
        input  wb_wen_i, wb_wdest_i, wb_wdata_i, lu_valid_i, lu_wdest_i, lu_wdata_i, qry_addr_i,
        output wb_stall_o, lu_ready_o, qry_hit_o, rf_wen_o, rf_wdest_o, rf_wdata_o
    );

    modport master (
        output wb_wen_i, wb_wdest_i, wb_wdata_i, lu_valid_i, lu_wdest_i, lu_wdata_i, qry_addr_i,
        input  wb_stall_o, lu_ready_o, qry_hit_o, rf_wen_o, rf_wdest_o, rf_wdata_o
    );
endinterface

// File: rtl/rf_wport_arb.sv
// rf_wport_arb: register-file write-port arbiter between WB and a buffered long-latency unit
//   clk_i - clock, rst_i - asynchronous active-low reset
//   bus   - rf_wport_arb_if.slave: WB request/stall, LU result/ready, pending-write query, rf write
//   RF_ARB_STARVE_GUARD_EN: when defined, WB wins are counted while LU results wait and the
//   FIFO is forced through (stalling WB) after STARVE_MAX consecutive WB wins.
module rf_wport_arb #(
    parameter int FIFO_DEPTH = 4
`ifdef RF_ARB_STARVE_GUARD_EN
    , parameter int STARVE_MAX = 8
`endif
) (
    input logic           clk_i,
    input logic           rst_i,
    rf_wport_arb_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [4:0]    dest_q [FIFO_DEPTH];
    logic [4:0]    dest_d [FIFO_DEPTH];
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   data_d [FIFO_DEPTH];
    logic          empty, full, wb_req, fifo_req, force_lu, pop, grant_wb, push, hit;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;
`endif

    always_comb begin
        empty    = count_q == '0;
        full     = count_q == (AW+1)'(FIFO_DEPTH);
        wb_req   = bus.wb_wen_i & (bus.wb_wdest_i != 5'd0);
        fifo_req = !empty;
`ifdef RF_ARB_STARVE_GUARD_EN
        force_lu = (starve_q == SW'(STARVE_MAX)) & wb_req & fifo_req;
`else
        force_lu = 1'b0;
`endif
        // rst_i gating keeps every output quiet while reset is held
        pop            = rst_i & fifo_req & (force_lu | !wb_req);
        grant_wb       = rst_i & wb_req & !force_lu;
        bus.wb_stall_o = rst_i & force_lu;
        // readiness comes from the registered count, so a same-cycle pop frees nothing
        bus.lu_ready_o = rst_i & !full;
        push           = bus.lu_valid_i & bus.lu_ready_o & (bus.lu_wdest_i != 5'd0);
        bus.rf_wen_o   = pop | grant_wb;
        bus.rf_wdest_o = pop ? dest_q[rd_ptr_q] : grant_wb ? bus.wb_wdest_i : 5'd0;
        bus.rf_wdata_o = pop ? data_q[rd_ptr_q] : grant_wb ? bus.wb_wdata_i : 32'd0;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        dest_d   = dest_q;
        data_d   = data_q;
        if (push) begin
            dest_d[wr_ptr_q] = bus.lu_wdest_i;
            data_d[wr_ptr_q] = bus.lu_wdata_i;
        end
        // head entry still counts while being popped: conservative for issue
        hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if ((AW+1)'(i) < count_q && dest_q[rd_ptr_q + AW'(i)] == bus.qry_addr_i)
                hit = 1'b1;
        bus.qry_hit_o = rst_i & (bus.qry_addr_i != 5'd0) & hit;
`ifdef RF_ARB_STARVE_GUARD_EN
        starve_d = (!fifo_req || pop) ? '0 :
                   (grant_wb && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dest_q   <= '{default: '0};
            data_q   <= '{default: '0};
`ifdef RF_ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
`ifdef RF_ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end
endmodule

// File: tb/tb_rf_wport_arb.sv
// tb_rf_wport_arb: directed self-checking bench for rf_wport_arb
module tb_rf_wport_arb;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    rf_wport_arb_if bus ();
    rf_wport_arb dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] dest, input logic [31:0] data);
        bus.wb_wen_i   = en;
        bus.wb_wdest_i = dest;
        bus.wb_wdata_i = data;
    endtask

    task automatic lu(input logic v, input logic [4:0] dest, input logic [31:0] data);
        bus.lu_valid_i = v;
        bus.lu_wdest_i = dest;
        bus.lu_wdata_i = data;
    endtask

    initial begin
        rst_i = 1'b0;
        wb(1'b1, 5'd3, 32'h1);
        lu(1'b1, 5'd5, 32'h2);
        bus.qry_addr_i = 5'd5;
        @(negedge clk_i);
        chk("rst_wen", bus.rf_wen_o, 0);
        chk("rst_ready", bus.lu_ready_o, 0);
        chk("rst_stall", bus.wb_stall_o, 0);
        chk("rst_hit", bus.qry_hit_o, 0);
        chk("rst_wdest", bus.rf_wdest_o, 0);
        chk("rst_wdata", bus.rf_wdata_o, 0);
        cyc();
        rst_i = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        lu(1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        chk("rel_ready", bus.lu_ready_o, 1);
        chk("rel_wen", bus.rf_wen_o, 0);
        cyc();

        // WB write lands combinationally
        wb(1'b1, 5'd3, 32'hDEADBEEF);
        @(negedge clk_i);
        chk("wb_wen", bus.rf_wen_o, 1);
        chk("wb_wdest", bus.rf_wdest_o, 3);
        chk("wb_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        chk("wb_stall", bus.wb_stall_o, 0);
        cyc();

        // LU result, 1-cycle latency, query hit until drained
        wb(1'b0, 5'd0, 32'h0);
        lu(1'b1, 5'd7, 32'h1234);
        bus.qry_addr_i = 5'd7;
        @(negedge clk_i);
        chk("lu_acc_wen", bus.rf_wen_o, 0);
        chk("lu_acc_hit", bus.qry_hit_o, 0);
        cyc();
        lu(1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        chk("lu_wen", bus.rf_wen_o, 1);
        chk("lu_wdest", bus.rf_wdest_o, 7);
        chk("lu_wdata", bus.rf_wdata_o, 32'h1234);
        chk("lu_hit", bus.qry_hit_o, 1);
        cyc();
        @(negedge clk_i);
        chk("lu_idle_wen", bus.rf_wen_o, 0);
        chk("lu_nohit", bus.qry_hit_o, 0);
        cyc();

        // fill the FIFO behind continuous WB traffic
        for (int i = 0; i < 4; i++) begin
            wb(1'b1, 5'd1, 32'hA0 + i);
            lu(1'b1, 5'(8 + i), 32'h100 + i);
            @(negedge clk_i);
            chk("fill_wdest", bus.rf_wdest_o, 1);
            chk("fill_ready", bus.lu_ready_o, 1);
            cyc();
        end
        lu(1'b1, 5'd12, 32'h104);
        wb(1'b1, 5'd1, 32'hB0);
        bus.qry_addr_i = 5'd8;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk_i);
            chk("full_ready", bus.lu_ready_o, 0);
            chk("full_wdata", bus.rf_wdata_o, 32'hB0);
            chk("full_hit", bus.qry_hit_o, 1);
            cyc();
        end
        wb(1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        chk("drain0_wdest", bus.rf_wdest_o, 8);
        chk("drain0_wdata", bus.rf_wdata_o, 32'h100);
        chk("drain0_ready", bus.lu_ready_o, 0);
        chk("drain0_hit", bus.qry_hit_o, 1);
        cyc();
        @(negedge clk_i);
        chk("drain1_wdest", bus.rf_wdest_o, 9);
        chk("drain1_ready", bus.lu_ready_o, 1);
        cyc();
        lu(1'b0, 5'd0, 32'h0);
        for (int k = 2; k < 4; k++) begin
            @(negedge clk_i);
            chk("drain_wdest", bus.rf_wdest_o, 32'(8 + k));
            chk("drain_wdata", bus.rf_wdata_o, 32'h100 + k);
            cyc();
        end
        bus.qry_addr_i = 5'd12;
        @(negedge clk_i);
        chk("drain4_wdest", bus.rf_wdest_o, 12);
        chk("drain4_wdata", bus.rf_wdata_o, 32'h104);
        chk("drain4_hit", bus.qry_hit_o, 1);
        cyc();
        @(negedge clk_i);
        chk("drained_wen", bus.rf_wen_o, 0);
        chk("drained_hit", bus.qry_hit_o, 0);
        cyc();

        // starvation: one LU entry behind continuous WB
        wb(1'b1, 5'd2, 32'h55);
        lu(1'b1, 5'd13, 32'h77);
        bus.qry_addr_i = 5'd13;
        @(negedge clk_i);
        chk("starve0_wdest", bus.rf_wdest_o, 2);
        cyc();
        lu(1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            chk("starve_wdest", bus.rf_wdest_o, (GUARD && i == 9) ? 32'd13 : 32'd2);
            chk("starve_stall", bus.wb_stall_o, (GUARD && i == 9) ? 32'd1 : 32'd0);
            chk("starve_hit", bus.qry_hit_o, (GUARD && i > 9) ? 32'd0 : 32'd1);
            cyc();
        end
        wb(1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        chk("starve_end_wen", bus.rf_wen_o, GUARD ? 32'd0 : 32'd1);
        chk("starve_end_wdest", bus.rf_wdest_o, GUARD ? 32'd0 : 32'd13);
        cyc();

        // r0 handling on both sources
        wb(1'b1, 5'd4, 32'h44);
        lu(1'b1, 5'd14, 32'h99);
        @(negedge clk_i);
        chk("r0_pre_wdest", bus.rf_wdest_o, 4);
        cyc();
        wb(1'b1, 5'd0, 32'hFF);
        lu(1'b1, 5'd0, 32'h88);
        bus.qry_addr_i = 5'd0;
        @(negedge clk_i);
        chk("r0_wb_wen", bus.rf_wen_o, 1);
        chk("r0_wb_wdest", bus.rf_wdest_o, 14);
        chk("r0_wb_wdata", bus.rf_wdata_o, 32'h99);
        chk("r0_lu_ready", bus.lu_ready_o, 1);
        chk("r0_qry_hit", bus.qry_hit_o, 0);
        cyc();
        wb(1'b0, 5'd0, 32'h0);
        lu(1'b0, 5'd0, 32'h0);
        bus.qry_addr_i = 5'd14;
        @(negedge clk_i);
        chk("r0_lu_wen", bus.rf_wen_o, 0);
        chk("r0_lu_hit", bus.qry_hit_o, 0);
        cyc();

        // reset mid-operation discards buffered entries
        wb(1'b1, 5'd1, 32'h11);
        lu(1'b1, 5'd20, 32'h22);
        cyc();
        wb(1'b0, 5'd0, 32'h0);
        lu(1'b0, 5'd0, 32'h0);
        rst_i = 1'b0;
        bus.qry_addr_i = 5'd20;
        @(negedge clk_i);
        chk("mrst_wen", bus.rf_wen_o, 0);
        chk("mrst_ready", bus.lu_ready_o, 0);
        cyc();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mrst_rel_wen", bus.rf_wen_o, 0);
        chk("mrst_rel_hit", bus.qry_hit_o, 0);
        chk("mrst_rel_ready", bus.lu_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
